// File: rtl/ram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_resp_pkg
// Brief    : Shared types and default sizing for the RAM line responder.
// Revision : 1.0
// ============================================================================
package ram_resp_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_LINE_W  = 128;
    localparam int DEF_LATENCY = 4;

    // Wide enough for the largest legal LATENCY-1 (14).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : ram_resp_pkg
`default_nettype wire

// File: rtl/ram_line_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_line_responder_if
// Brief    : Cache <-> RAM line request/response handshake bundle.
// Revision : 1.0
// ============================================================================
interface ram_line_responder_if #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 128
);

    logic              enable_cache_to_ram;
    logic              write_cache_to_ram;
    logic [ADDR_W-1:0] addr_cache_to_ram;
    logic [LINE_W-1:0] data_cache_to_ram;
    logic [LINE_W-1:0] data_ram_to_cache;
    logic              response_ram_to_cache;
    logic              ram_busy;

    // Cache controller side.
    modport master (
        output enable_cache_to_ram,
        output write_cache_to_ram,
        output addr_cache_to_ram,
        output data_cache_to_ram,
        input  data_ram_to_cache,
        input  response_ram_to_cache,
        input  ram_busy
    );

    // Memory side.
    modport slave (
        input  enable_cache_to_ram,
        input  write_cache_to_ram,
        input  addr_cache_to_ram,
        input  data_cache_to_ram,
        output data_ram_to_cache,
        output response_ram_to_cache,
        output ram_busy
    );

endinterface : ram_line_responder_if
`default_nettype wire

// File: rtl/ram_line_array.sv
`default_nettype none
// ============================================================================
// Module   : ram_line_array
// Brief    : Synchronous single-port line store with registered read port.
// Revision : 1.0
// ============================================================================
module ram_line_array #(
    parameter int ADDR_W = 8,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] r_mem [2**ADDR_W];

    // Storage is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read register holds the last fill; writes never disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule : ram_line_array
`default_nettype wire

// File: rtl/ram_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_line_responder
// Brief    : Fixed-latency memory-side responder for cache line fill/writeback.
// Revision : 1.0
// ============================================================================
module ram_line_responder
    import ram_resp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_line_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [LINE_W-1:0] r_wdata;
    logic              r_response;
    logic              r_busy;

    logic              w_access;
    logic              w_we;
    logic              w_re;
    logic [LINE_W-1:0] w_rdata;

    // The access edge is the last WAIT cycle; reset forces IDLE so an aborted
    // writeback can never reach the store.
    assign w_access = (r_state == WAIT) && (r_cnt == '0);
    assign w_we     = w_access &&  r_write;
    assign w_re     = w_access && !r_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_response <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_response <= 1'b0;
                    if (bus.enable_cache_to_ram) begin
                        r_addr  <= bus.addr_cache_to_ram;
                        r_write <= bus.write_cache_to_ram;
                        r_wdata <= bus.data_cache_to_ram;
                        r_cnt   <= C_CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_response <= 1'b1;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_response <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_response <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    ram_line_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .re    (w_re),
        .addr  (r_addr),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    assign bus.data_ram_to_cache     = w_rdata;
    assign bus.response_ram_to_cache = r_response;
    assign bus.ram_busy              = r_busy;

endmodule : ram_line_responder
`default_nettype wire

// File: tb/tb_ram_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_line_responder
// Brief    : Directed self-checking bench for LATENCY=4 and LATENCY=1 builds.
// Revision : 1.0
// ============================================================================
module tb_ram_line_responder;
    import ram_resp_pkg::*;

    localparam int LAT = 4;

    localparam logic [127:0] P_A5   = {16{8'hA5}};
    localparam logic [127:0] P_5A   = {16{8'h5A}};
    localparam logic [127:0] P_05   = {8{16'h0505}};
    localparam logic [127:0] P_DB   = {4{32'hDEADBEEF}};
    localparam logic [127:0] P_BAD  = {4{32'hBAD0BAD0}};
    localparam logic [127:0] P_1A   = {4{32'h1111AAAA}};
    localparam logic [127:0] P_ONES = {128{1'b1}};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_line_responder_if #(.ADDR_W(DEF_ADDR_W), .LINE_W(DEF_LINE_W)) b4 ();
    ram_line_responder_if #(.ADDR_W(DEF_ADDR_W), .LINE_W(DEF_LINE_W)) b1 ();

    ram_line_responder #(.ADDR_W(DEF_ADDR_W), .LINE_W(DEF_LINE_W), .LATENCY(LAT)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    ram_line_responder #(.ADDR_W(DEF_ADDR_W), .LINE_W(DEF_LINE_W), .LATENCY(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with u4 idle; leaves one cycle after the response.
    task automatic xfer4(input logic wr, input logic [7:0] a, input logic [127:0] d, input string tag);
        b4.enable_cache_to_ram = 1'b1;
        b4.write_cache_to_ram  = wr;
        b4.addr_cache_to_ram   = a;
        b4.data_cache_to_ram   = d;
        @(negedge clk);
        b4.enable_cache_to_ram = 1'b0;
        repeat (LAT) @(negedge clk);
        chk_bit({tag, "_resp"}, b4.response_ram_to_cache, 1'b1);
        @(negedge clk);
        chk_bit({tag, "_done"}, b4.response_ram_to_cache, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        b4.enable_cache_to_ram = 1'b0;
        b4.write_cache_to_ram  = 1'b0;
        b4.addr_cache_to_ram   = '0;
        b4.data_cache_to_ram   = '0;
        b1.enable_cache_to_ram = 1'b0;
        b1.write_cache_to_ram  = 1'b0;
        b1.addr_cache_to_ram   = '0;
        b1.data_cache_to_ram   = '0;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_bit ("rst_resp4",  b4.response_ram_to_cache, 1'b0);
        chk_bit ("rst_busy4",  b4.ram_busy, 1'b0);
        chk_line("rst_data4",  b4.data_ram_to_cache, '0);
        chk_bit ("rst_idle4",  u4.r_state == IDLE, 1'b1);
        chk_bit ("rst_resp1",  b1.response_ram_to_cache, 1'b0);
        chk_bit ("rst_busy1",  b1.ram_busy, 1'b0);
        chk_line("rst_data1",  b1.data_ram_to_cache, '0);

        // Preload lines through writebacks; fill data must stay untouched
        xfer4(1'b1, 8'h12, P_A5, "pre12");
        xfer4(1'b1, 8'h34, P_5A, "pre34");
        xfer4(1'b1, 8'h05, P_05, "pre05");
        chk_line("wb_keeps_data", b4.data_ram_to_cache, '0);

        // Fill timing on 0x12
        b4.enable_cache_to_ram = 1'b1;
        b4.write_cache_to_ram  = 1'b0;
        b4.addr_cache_to_ram   = 8'h12;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) b4.enable_cache_to_ram = 1'b0;
            chk_bit($sformatf("fill_resp_e%0d", k), b4.response_ram_to_cache, k == 4);
            chk_bit($sformatf("fill_busy_e%0d", k), b4.ram_busy, k <= 4);
            if (k >= 4)      chk_line($sformatf("fill_data_e%0d", k), b4.data_ram_to_cache, P_A5);
            else if (k == 3) chk_line("fill_data_e3", b4.data_ram_to_cache, '0);
        end

        // Writeback then fill on 0x20 with enable held high
        b4.enable_cache_to_ram = 1'b1;
        b4.write_cache_to_ram  = 1'b1;
        b4.addr_cache_to_ram   = 8'h20;
        b4.data_cache_to_ram   = P_DB;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 4) b4.write_cache_to_ram  = 1'b0;
            if (k == 6) b4.enable_cache_to_ram = 1'b0;
            chk_bit($sformatf("wf_resp_e%0d", k), b4.response_ram_to_cache, (k == 4) || (k == 10));
            chk_bit($sformatf("wf_busy_e%0d", k), b4.ram_busy, (k <= 4) || (k >= 6 && k <= 10));
            if (k == 4)  chk_line("wf_wb_data_held", b4.data_ram_to_cache, P_A5);
            if (k == 5)  chk_bit("wf_idle_e5", u4.r_state == IDLE, 1'b1);
            if (k == 6)  chk_bit("wf_accept_e6", u4.r_state == WAIT, 1'b1);
            if (k >= 10) chk_line($sformatf("wf_data_e%0d", k), b4.data_ram_to_cache, P_DB);
        end

        // Inputs change during WAIT; the captured read of 0x12 must complete
        b4.enable_cache_to_ram = 1'b1;
        b4.write_cache_to_ram  = 1'b0;
        b4.addr_cache_to_ram   = 8'h12;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b4.addr_cache_to_ram  = 8'h34;
                b4.write_cache_to_ram = 1'b1;
                b4.data_cache_to_ram  = P_ONES;
            end
            if (k == 3) b4.enable_cache_to_ram = 1'b0;
            if (k == 4) begin
                chk_bit ("chg_resp", b4.response_ram_to_cache, 1'b1);
                chk_line("chg_data", b4.data_ram_to_cache, P_A5);
            end
            if (k == 5) chk_bit("chg_idle", u4.r_state == IDLE, 1'b1);
        end
        xfer4(1'b0, 8'h34, '0, "rd34");
        chk_line("chg_store34", b4.data_ram_to_cache, P_5A);

        // Reset during WAIT of a writeback to 0x05
        b4.enable_cache_to_ram = 1'b1;
        b4.write_cache_to_ram  = 1'b1;
        b4.addr_cache_to_ram   = 8'h05;
        b4.data_cache_to_ram   = P_BAD;
        @(negedge clk);
        b4.enable_cache_to_ram = 1'b0;
        repeat (2) @(negedge clk);
        chk_bit("abort_cnt1", u4.r_cnt == 4'd1, 1'b1);
        rst = 1'b0;
        #1;
        chk_bit ("abort_resp", b4.response_ram_to_cache, 1'b0);
        chk_bit ("abort_busy", b4.ram_busy, 1'b0);
        chk_bit ("abort_idle", u4.r_state == IDLE, 1'b1);
        chk_line("abort_data", b4.data_ram_to_cache, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_bit($sformatf("abort_noresp_%0d", k), b4.response_ram_to_cache, 1'b0);
        end
        xfer4(1'b0, 8'h05, '0, "rd05");
        chk_line("abort_store05", b4.data_ram_to_cache, P_05);

        // LATENCY=1 build: back-to-back acceptances 3 edges apart
        b1.enable_cache_to_ram = 1'b1;
        b1.write_cache_to_ram  = 1'b1;
        b1.addr_cache_to_ram   = 8'h03;
        b1.data_cache_to_ram   = P_1A;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) b1.write_cache_to_ram  = 1'b0;
            if (k == 4) b1.enable_cache_to_ram = 1'b0;
            chk_bit($sformatf("l1_resp_e%0d", k), b1.response_ram_to_cache, (k == 1) || (k == 4));
            chk_bit($sformatf("l1_busy_e%0d", k), b1.ram_busy, (k <= 1) || (k >= 3 && k <= 4));
            if (k == 1) chk_line("l1_data_wb", b1.data_ram_to_cache, '0);
            if (k >= 4) chk_line($sformatf("l1_data_e%0d", k), b1.data_ram_to_cache, P_1A);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_line_responder
`default_nettype wire

// File: doc/ram_line_responder.md
# ram_line_responder

Memory-side responder for the data-cache refill/writeback protocol. It accepts whole-line requests from the cache controller over the enable/write/response handshake, serves writebacks and fills after a fixed latency, and returns a single-cycle response strobe. It sits between the data cache and the backing line store, replacing an ideal zero-latency memory model.

## Interface
Parameters:
- ADDR_W, 8, line-address width; store depth is 2**ADDR_W lines.
- LINE_W, 128, cache line width in bits.
- LATENCY, 4, cycles spent in WAIT per request; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enable_cache_to_ram  in  1  request valid; level, not pulse.
- write_cache_to_ram  in  1  1 = writeback line, 0 = fill (read) line; qualified by enable.
- addr_cache_to_ram  in  ADDR_W  line address.
- data_cache_to_ram  in  LINE_W  writeback data.
- data_ram_to_cache  out  LINE_W  fill data.
- response_ram_to_cache  out  1  one-cycle completion strobe.
- ram_busy  out  1  high from the acceptance edge until the response cycle ends.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: enable high at an edge accepts the request.
  - Captures addr, write, wdata into request registers.
  - Loads cnt = LATENCY-1 and moves to WAIT.
  - Enable low keeps the FSM in IDLE.
- WAIT: inputs are ignored; the captured request is used.
  - If cnt == 0, performs the access at this edge and moves to RESP.
  - Writeback: line store[addr] <= wdata.
  - Fill: data_ram_to_cache <= store[addr].
  - Otherwise cnt decrements.
- RESP: response_ram_to_cache = 1 for exactly this cycle, then unconditional move to IDLE.
- The cache controller holds enable high across a writeback followed by a fill, changing write/addr on the response edge. The request still present in the next IDLE cycle is therefore accepted as a new request. This is required behaviour, not a spurious retrigger.
- data_ram_to_cache holds its value until the next fill completes; writebacks do not change it.
- Addresses are naturally modulo 2**ADDR_W; there is no range check.
- Reset values: state IDLE, cnt 0, response 0, ram_busy 0, data_ram_to_cache 0, request registers 0.
- The line store is not reset; its contents are unknown until written.
- Reset asserted mid-request aborts it. A pending writeback is not committed and no response is issued.

## Timing
- Acceptance at edge 0. Access occurs at edge LATENCY. Response is high between edges LATENCY and LATENCY+1.
- Fill data is valid in the same cycle as the response.
- Minimum spacing between acceptances: LATENCY+2 edges, because the IDLE re-sample follows RESP.
- response_ram_to_cache and ram_busy are registered outputs, with no combinational path from the inputs.
- Read-after-write to the same address returns the new data.
- Simultaneous reset and response: reset wins and the output is 0.

## Structure
- Shared package `ram_resp_pkg`:
  - state enum {IDLE, WAIT, RESP}
  - default LATENCY, ADDR_W, LINE_W constants, reused by the cache controller and bench.
- One sub-module, `ram_line_array`: synchronous single-port line store with write enable, ADDR_W x LINE_W.
- FSM, counter and request registers stay in the top module.

## Test plan
- Reset: rst low for 3 cycles, then high. Required: response 0, busy 0, data 0, FSM in IDLE.
- Fill timing (LATENCY=4): preload store[0x12] = 0xA5A5...; enable=1, write=0, addr=0x12 at edge 0. Required:
  - response high only between edges 4 and 5;
  - data = 0xA5A5... in that cycle and held afterwards.
- Writeback then fill on the same address: write 0xDEAD_BEEF...; enable held high, write dropped on the response edge. Required:
  - second request accepted one edge after RESP;
  - second response at +LATENCY;
  - returned data = 0xDEAD_BEEF....
- Input change during WAIT: change addr to 0x34 and write to 1 mid-WAIT. Required: the original read of 0x12 completes, and store[0x34] is unchanged.
- Reset mid-WAIT of a writeback to 0x05: drop rst at cnt=1. Required: no response; store[0x05] retains its old value; a new request after reset completes normally.
- LATENCY=1 build: acceptance at edge 0 gives response between edges 1 and 2. Back-to-back requests are spaced 3 edges apart.
